// File: rtl/cond_exec_stage.sv
// cond_exec_stage: execute-to-memory stage with NZCV flag register, condition gating and squash counter.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   valid_in, alu_result, alu_flags, cond, set_flags,
//   reg_write_in, mem_write_in, rd_in, store_data_in : instruction arriving from the ALU
//   stall, flush        : hold everything / replace the incoming instruction with a bubble
//   cond_pass           : combinational condition result against flags_q
//   valid_out, result_out, store_data_out, rd_out,
//   reg_write_out, mem_write_out : registered memory-stage instruction
//   flags_q             : architectural NZCV
//   squash_cnt          : saturating count of condition-failed instructions
module cond_exec_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic [3:0]        cond,
    input  logic              set_flags,
    input  logic              reg_write_in,
    input  logic              mem_write_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              stall,
    input  logic              flush,
    output logic              cond_pass,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              reg_write_out,
    output logic              mem_write_out,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  squash_cnt
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              mw_q, mw_d;
    logic [3:0]        flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              base;
    logic              exec;
    logic              n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Codes come in complementary pairs, so decode the pair and invert on cond[0];
    // the AL/NV pair falls out as 1/0 the same way.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = n == v;
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
    end

    assign cond_pass = base ^ cond[0];
    assign exec      = valid_in & cond_pass;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mw_d     = mw_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        if (!stall) begin
            valid_d  = ~flush & valid_in;
            result_d = flush ? '0 : alu_result;
            store_d  = flush ? '0 : store_data_in;
            rd_d     = flush ? '0 : rd_in;
            rw_d     = ~flush & reg_write_in & exec;
            mw_d     = ~flush & mem_write_in & exec;
            flags_d  = (~flush & exec & set_flags) ? alu_flags : flags_q;
            cnt_d    = (~flush & valid_in & ~cond_pass & (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            flags_q  <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mw_q     <= mw_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_out      = valid_q;
    assign result_out     = result_q;
    assign store_data_out = store_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = rw_q;
    assign mem_write_out  = mw_q;
    assign squash_cnt     = cnt_q;
endmodule

// File: tb/tb_cond_exec_stage.sv
// tb_cond_exec_stage: scoreboard bench for cond_exec_stage using directed vectors.
module tb_cond_exec_stage;
    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [31:0] sd;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic [3:0]  fl;
        logic [15:0] cnt;
    } st_t;

    typedef struct {
        int   tag;
        bit   is_cp;
        logic cp;
        st_t  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, valid_in, set_flags, reg_write_in, mem_write_in, stall, flush;
    logic [31:0] alu_result, store_data_in;
    logic [3:0]  alu_flags, cond, rd_in;
    logic        cond_pass, valid_out, reg_write_out, mem_write_out;
    logic [31:0] result_out, store_data_out;
    logic [3:0]  rd_out, flags_q;
    logic [15:0] squash_cnt;
    st_t         got;
    exp_t        q[$];
    exp_t        mon_e;
    int          edge_n = 0;
    int          errors = 0;
    int          checks = 0;

    cond_exec_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
        .alu_flags(alu_flags), .cond(cond), .set_flags(set_flags),
        .reg_write_in(reg_write_in), .mem_write_in(mem_write_in), .rd_in(rd_in),
        .store_data_in(store_data_in), .stall(stall), .flush(flush),
        .cond_pass(cond_pass), .valid_out(valid_out), .result_out(result_out),
        .store_data_out(store_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .mem_write_out(mem_write_out), .flags_q(flags_q), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    assign got = {valid_out, result_out, store_data_out, rd_out, reg_write_out, mem_write_out, flags_q, squash_cnt};

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= edge_n) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.is_cp) begin
                if (cond_pass !== mon_e.cp) begin
                    errors++;
                    $display("FAIL cond_pass edge %0d: got %b want %b", edge_n, cond_pass, mon_e.cp);
                end
            end else if (got !== mon_e.st) begin
                errors++;
                $display("FAIL state edge %0d: got v=%b res=%h sd=%h rd=%h rw=%b mw=%b fl=%b cnt=%h want v=%b res=%h sd=%h rd=%h rw=%b mw=%b fl=%b cnt=%h",
                         edge_n, got.v, got.res, got.sd, got.rd, got.rw, got.mw, got.fl, got.cnt,
                         mon_e.st.v, mon_e.st.res, mon_e.st.sd, mon_e.st.rd, mon_e.st.rw, mon_e.st.mw, mon_e.st.fl, mon_e.st.cnt);
            end
        end
    end

    function automatic st_t s_exp(input logic v, input logic [31:0] res, sd, input logic [3:0] rd,
                                  input logic rw, mw, input logic [3:0] fl, input logic [15:0] cnt);
        return '{v: v, res: res, sd: sd, rd: rd, rw: rw, mw: mw, fl: fl, cnt: cnt};
    endfunction

    // cp < 0 skips the cond_pass check; chk=0 skips the post-edge state check.
    task automatic vec(input logic r, s, f, v, input logic [3:0] c, input logic sf, input logic [3:0] af,
                       input logic [31:0] res, sd, input logic [3:0] rd, input logic rw, mw,
                       input int cp, input st_t e, input bit chk);
        exp_t x;
        reset = r; stall = s; flush = f; valid_in = v; cond = c; set_flags = sf; alu_flags = af;
        alu_result = res; store_data_in = sd; rd_in = rd; reg_write_in = rw; mem_write_in = mw;
        if (cp >= 0) begin
            x = '{tag: edge_n, is_cp: 1'b1, cp: cp[0], st: '0};
            q.push_back(x);
        end
        if (chk) begin
            x = '{tag: edge_n + 1, is_cp: 1'b0, cp: 1'b0, st: e};
            q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec(1,0,0,0,4'h0,0,4'h0,32'h0,32'h0,4'h0,0,0,-1, s_exp(0,0,0,0,0,0,4'h0,16'h0), 1);
        vec(1,0,0,0,4'h0,0,4'h0,32'h0,32'h0,4'h0,0,0, 0, s_exp(0,0,0,0,0,0,4'h0,16'h0), 1);
        vec(0,0,0,1,4'hE,1,4'b0100,32'h0,32'h0,4'h3,1,0, 1, s_exp(1,32'h0,32'h0,4'h3,1,0,4'b0100,16'd0), 1);
        vec(0,0,0,1,4'h1,1,4'b1000,32'h11,32'h22,4'h5,1,1, 0, s_exp(1,32'h11,32'h22,4'h5,0,0,4'b0100,16'd1), 1);
        vec(0,0,0,1,4'hE,1,4'b1001,32'h33,32'h44,4'h1,0,1, 1, s_exp(1,32'h33,32'h44,4'h1,0,1,4'b1001,16'd1), 1);
        vec(0,0,0,1,4'hA,0,4'h0,32'h55,32'h0,4'h2,1,0, 1, s_exp(1,32'h55,32'h0,4'h2,1,0,4'b1001,16'd1), 1);
        vec(0,0,0,1,4'hC,0,4'h0,32'h66,32'h0,4'h3,1,0, 1, s_exp(1,32'h66,32'h0,4'h3,1,0,4'b1001,16'd1), 1);
        vec(0,0,0,1,4'hB,0,4'h0,32'h77,32'h0,4'h4,1,1, 0, s_exp(1,32'h77,32'h0,4'h4,0,0,4'b1001,16'd2), 1);
        vec(0,0,0,1,4'hF,0,4'h0,32'h88,32'h0,4'h5,1,0, 0, s_exp(1,32'h88,32'h0,4'h5,0,0,4'b1001,16'd3), 1);
        vec(0,0,0,1,4'hE,1,4'b0010,32'h99,32'h0,4'h0,0,0, 1, s_exp(1,32'h99,32'h0,4'h0,0,0,4'b0010,16'd3), 1);
        vec(0,0,0,1,4'h8,0,4'h0,32'hA0,32'h0,4'h6,1,0, 1, s_exp(1,32'hA0,32'h0,4'h6,1,0,4'b0010,16'd3), 1);
        vec(0,0,0,1,4'h9,0,4'h0,32'hA1,32'h0,4'h7,1,0, 0, s_exp(1,32'hA1,32'h0,4'h7,0,0,4'b0010,16'd4), 1);
        vec(0,0,0,0,4'hF,0,4'h0,32'hB0,32'h0,4'h8,1,0, 0, s_exp(0,32'hB0,32'h0,4'h8,0,0,4'b0010,16'd4), 1);
        vec(0,1,0,1,4'hE,1,4'b1111,32'hC0,32'hC1,4'h9,1,1, 1, s_exp(0,32'hB0,32'h0,4'h8,0,0,4'b0010,16'd4), 1);
        vec(0,1,0,1,4'hF,0,4'h0,32'hC2,32'hC3,4'hA,1,0, 0, s_exp(0,32'hB0,32'h0,4'h8,0,0,4'b0010,16'd4), 1);
        vec(0,1,1,1,4'h2,1,4'b0111,32'hC4,32'hC5,4'hB,0,1, 1, s_exp(0,32'hB0,32'h0,4'h8,0,0,4'b0010,16'd4), 1);
        vec(0,0,0,1,4'hE,1,4'b1100,32'hD0,32'hD1,4'h9,1,0, 1, s_exp(1,32'hD0,32'hD1,4'h9,1,0,4'b1100,16'd4), 1);
        vec(0,0,1,1,4'hE,1,4'b0001,32'hE0,32'hE1,4'hA,1,1, 1, s_exp(0,32'h0,32'h0,4'h0,0,0,4'b1100,16'd4), 1);
        vec(0,0,1,1,4'hF,0,4'h0,32'hE2,32'hE3,4'hB,1,1, 0, s_exp(0,32'h0,32'h0,4'h0,0,0,4'b1100,16'd4), 1);
        vec(0,0,0,1,4'hE,0,4'h0,32'hF0,32'hF1,4'hB,0,1, 1, s_exp(1,32'hF0,32'hF1,4'hB,0,1,4'b1100,16'd4), 1);
        vec(0,1,1,1,4'hE,1,4'b0011,32'hF2,32'hF3,4'hC,1,1, 1, s_exp(1,32'hF0,32'hF1,4'hB,0,1,4'b1100,16'd4), 1);
        for (int i = 0; i < 65530; i++)
            vec(0,0,0,1,4'hF,0,4'h0,32'h0,32'h0,4'h0,0,0,-1, s_exp(1,0,0,0,0,0,4'b1100,16'hFFFE), i == 65529);
        for (int i = 0; i < 3; i++)
            vec(0,0,0,1,4'hF,1,4'hF,32'h0,32'h0,4'h0,1,1, 0, s_exp(1,0,0,0,0,0,4'b1100,16'hFFFF), 1);
        vec(1,1,0,1,4'hE,1,4'hF,32'h1,32'h2,4'h3,1,1,-1, s_exp(0,0,0,0,0,0,4'h0,16'h0), 1);
        vec(0,0,0,0,4'h0,0,4'h0,32'h0,32'h0,4'h0,0,0, 0, s_exp(0,0,0,0,0,0,4'h0,16'h0), 1);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unconsumed, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
